// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper for a 4-input combinational block.
// Drives every input vector 0..15 on {a,b,c,d}, waits SETTLE cycles for the
// block under test to settle, then samples its output s into a captured
// table. Each sample is compared against a golden table, and the sweeper
// keeps a per-vector mismatch map and a count of mismatching vectors.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; vector outputs low; results of last sweep held
// DRIVE  | current vector driven; settle counter runs for SETTLE cycles
// SAMPLE | one cycle: capture s, compare to golden bit, advance or finish
// FIN    | one cycle: done pulse, pass updated from final error count
//
// One vector therefore occupies SETTLE+1 busy cycles, so a sweep is
// 16*(SETTLE+1) busy cycles, followed by the FIN cycle.
// All outputs are registered.

module truth_table_sweeper #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        s,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] captured_table,
  output logic [15:0] mismatch,
  output logic [4:0]  err_count,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] IDX_LAST    = 4'd15;

  state_t     state;
  logic [3:0] idx;
  logic [3:0] settle_cnt;
  logic [3:0] vec;

  // The vector register sits directly on the four outputs so the block
  // under test sees glitch-free, clock-aligned inputs.
  assign {a, b, c, d} = vec;

  // Sweep sequencer: state transitions, vector/settle bookkeeping and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= 4'd0;
      settle_cnt     <= 4'd0;
      vec            <= 4'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      captured_table <= 16'h0000;
      mismatch       <= 16'h0000;
      err_count      <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          vec  <= 4'd0;
          if (start) begin
            captured_table <= 16'h0000;
            mismatch       <= 16'h0000;
            err_count      <= 5'd0;
            pass           <= 1'b0;
            idx            <= 4'd0;
            settle_cnt     <= 4'd0;
            vec            <= 4'd0;
            busy           <= 1'b1;
            state          <= DRIVE;
          end
        end

        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        SAMPLE: begin
          captured_table[idx] <= s;
          mismatch[idx]       <= s ^ expected[idx];
          if (s != expected[idx]) begin
            err_count <= err_count + 5'd1;
          end
          if (idx == IDX_LAST) begin
            // vec returns to zero together with busy so the block under
            // test is parked while the sweeper is not sweeping.
            vec   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            idx        <= idx + 4'd1;
            vec        <= idx + 4'd1;
            settle_cnt <= 4'd0;
            state      <= DRIVE;
          end
        end

        FIN: begin
          // err_count already includes the vector-15 result written in SAMPLE.
          done  <= 1'b0;
          pass  <= (err_count == 5'd0);
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper (SETTLE = 2).
// The device under test is modelled as an arbitrary 4-input function held as
// a 16-entry lookup (fn), so s = fn[{a,b,c,d}]. The reference results for a
// sweep follow directly from that function and the golden table: the
// captured table equals fn, mismatch is fn ^ golden, the error count is the
// number of set mismatch bits, and pass means that count is zero.

module tb_truth_table_sweeper;

  localparam int SETTLE     = 2;
  localparam int HOLD       = SETTLE + 1;
  localparam int SWEEP_BUSY = 16 * HOLD;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] expected;
  logic        s;
  logic        a, b, c, d;
  logic        busy;
  logic        done;
  logic [15:0] tbl;
  logic [15:0] mismatch;
  logic [4:0]  err_count;
  logic        pass;

  logic [15:0] fn;

  int n_cmp;
  int n_err;

  truth_table_sweeper #(.SETTLE(SETTLE)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .expected      (expected),
    .s             (s),
    .a             (a),
    .b             (b),
    .c             (c),
    .d             (d),
    .busy          (busy),
    .done          (done),
    .captured_table(tbl),
    .mismatch      (mismatch),
    .err_count     (err_count),
    .pass          (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational stand-in for the block being characterised.
  always_comb s = fn[{a, b, c, d}];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic [15:0] f, input logic [15:0] g);
    logic [15:0] mm;
    mm = f ^ g;
    check({tag, "_table"},    32'(tbl),       32'(f));
    check({tag, "_mismatch"}, 32'(mismatch),  32'(mm));
    check({tag, "_errcnt"},   32'(err_count), 32'($countones(mm)));
    check({tag, "_pass"},     32'(pass),      32'(mm == 16'h0000));
  endtask

  // Runs one sweep and checks timing, vector order and results.
  // Entered and left at a negedge. With hold=1 start is left high.
  task automatic run_sweep(input string tag, input logic [15:0] f, input logic [15:0] g,
                           input bit hold, input int exp_wait);
    int waits;
    int nbusy;
    int first_bad;
    logic [3:0] trace[$];

    fn       = f;
    expected = g;
    start    = 1'b1;
    waits    = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!busy && waits < 20);
    if (!hold) start = 1'b0;
    check({tag, "_start_wait"}, 32'(waits), 32'(exp_wait));

    nbusy = 0;
    while (busy && nbusy < 200) begin
      trace.push_back({a, b, c, d});
      nbusy++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 32'(nbusy), 32'(SWEEP_BUSY));

    first_bad = -1;
    for (int k = 0; k < trace.size(); k++) begin
      if (first_bad < 0 && trace[k] != 4'(k / HOLD)) first_bad = k;
    end
    check({tag, "_vec_order"}, 32'(first_bad), 32'hFFFF_FFFF);

    // FIN cycle
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_fin_vec"}, 32'({a, b, c, d}), 32'd0);
    @(negedge clk);
    // first IDLE cycle: results final
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_results(tag, f, g);
  endtask

  initial begin
    int guard;
    bit saw_done;
    logic [15:0] rf;
    logic [15:0] rg;

    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    start    = 1'b1;
    expected = 16'h1234;
    fn       = 16'h0000;

    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_vec",   32'({a, b, c, d}), 32'd0);
    check("rst_table", 32'(tbl), 32'd0);
    check("rst_mm",    32'(mismatch), 32'd0);
    check("rst_err",   32'(err_count), 32'd0);
    check("rst_pass",  32'(pass), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("idle_no_start", 32'(busy), 32'd0);

    run_sweep("zero",  16'h0000, 16'h0000, 1'b0, 1);
    run_sweep("ones",  16'hFFFF, 16'h0000, 1'b0, 1);
    run_sweep("d_in",  16'hAAAA, 16'hAAAA, 1'b0, 1);
    run_sweep("a_and_b", 16'hF000, 16'h7000, 1'b0, 1);

    // results held through IDLE
    repeat (7) @(negedge clk);
    check_results("hold", 16'hF000, 16'h7000);

    // reset in the middle of vector 7
    fn       = 16'h0F0F;
    expected = 16'h0000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while ({a, b, c, d} != 4'd7 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reach7", 32'({a, b, c, d}), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_done",  32'(done), 32'd0);
    check("abort_vec",   32'({a, b, c, d}), 32'd0);
    check("abort_table", 32'(tbl), 32'd0);
    check("abort_mm",    32'(mismatch), 32'd0);
    check("abort_err",   32'(err_count), 32'd0);
    check("abort_pass",  32'(pass), 32'd0);
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_quiet", 32'(saw_done), 32'd0);
    run_sweep("post_abort", 16'h6996, 16'h6996, 1'b0, 1);

    // start held high: back-to-back sweeps with one IDLE cycle between
    run_sweep("held1", 16'h8001, 16'h0000, 1'b1, 1);
    run_sweep("held2", 16'h0000, 16'h0000, 1'b1, 1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("held_stop", 32'(busy), 32'd0);
    check_results("held_final", 16'h0000, 16'h0000);

    // random functions against random golden tables
    for (int r = 0; r < 6; r++) begin
      rf = 16'($urandom);
      rg = (r % 2 == 0) ? rf ^ 16'($urandom & $urandom) : 16'($urandom);
      run_sweep($sformatf("rand%0d", r), rf, rg, 1'b0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter: SETTLE, default 2, number of cycles each input vector is held before s is sampled; legal range 1..15.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  sweep request; sampled only in IDLE.
REQ-005 Port: expected  input  16  golden truth table; bit i is the expected s for vector i.
REQ-006 Port: a  output  1  DUT input, vector bit 3 (MSB).
REQ-007 Port: b  output  1  DUT input, vector bit 2.
REQ-008 Port: c  output  1  DUT input, vector bit 1.
REQ-009 Port: d  output  1  DUT input, vector bit 0 (LSB).
REQ-010 Port: s  input  1  DUT output, combinational response to a,b,c,d.
REQ-011 Port: busy  output  1  high while a sweep is in progress.
REQ-012 Port: done  output  1  one-cycle pulse at sweep completion.
REQ-013 Port: table  output  16  captured truth table; bit i is s sampled for vector i.
REQ-014 Port: mismatch  output  16  bit i = table[i] XOR expected[i], set at sample time.
REQ-015 Port: err_count  output  5  number of mismatching vectors, 0..16.
REQ-016 Port: pass  output  1  high when last completed sweep had err_count == 0.

Function
REQ-017 FSM states SHALL be IDLE, DRIVE, SAMPLE, FIN.
REQ-018 IDLE: start=1 -> clear table, mismatch, err_count, pass; vector index idx=0; settle counter=0; go to DRIVE.
REQ-019 {a,b,c,d} SHALL equal idx (registered) in DRIVE and SAMPLE; 4'b0000 in IDLE and FIN.
REQ-020 DRIVE SHALL last exactly SETTLE cycles, then go to SAMPLE.
REQ-021 SAMPLE (one cycle): table[idx] <= s; mismatch[idx] <= s ^ expected[idx]; err_count increments when they differ.
REQ-022 SAMPLE: idx==15 -> FIN; otherwise idx <= idx+1, counter cleared, go to DRIVE; idx SHALL never wrap within a sweep.
REQ-023 FIN (one cycle): done=1, busy=0, pass <= (err_count_final == 0) including the vector-15 result; go to IDLE.
REQ-024 busy SHALL be 1 in DRIVE and SAMPLE only; sweep length SHALL be 16*(SETTLE+1) busy cycles; done asserts on the next cycle.
REQ-025 start while not in IDLE (including the FIN cycle) SHALL be ignored, with no queuing.
REQ-026 expected SHALL be sampled per vector in SAMPLE; the caller holds it stable for the whole sweep.
REQ-027 table, mismatch, err_count, and pass SHALL hold their values in IDLE until the next accepted start.
REQ-028 err_count SHALL NOT saturate or wrap; maximum 16 fits 5 bits.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, idx=0, counter=0, and set a,b,c,d,busy,done,pass=0, table=0, mismatch=0, err_count=0.
REQ-030 rst SHALL take priority over start and over all FSM transitions, including mid-sweep abort with no done pulse.
REQ-031 After rst deasserts, the first accepted start SHALL begin a complete sweep from vector 0.

Verification
REQ-032 SETTLE=2, s tied 0, expected=16'h0000, start pulse -> busy for 48 cycles, done pulse, table=0000, err_count=0, pass=1.
REQ-033 s tied 1, expected=16'h0000 -> table=FFFF, mismatch=FFFF, err_count=16, pass=0.
REQ-034 s driven by d, expected=16'hAAAA -> table=AAAA, mismatch=0000, pass=1; check that a,b,c,d step 0..15 in order with each vector held 3 cycles.
REQ-035 s driven by a&b, expected=16'hF000 but bit 15 cleared (16'h7000) -> table=F000, mismatch=8000, err_count=1, pass=0, confirming the final-vector result reaches pass.
REQ-036 rst asserted at vector 7 -> next cycle all outputs 0, no done pulse; then start -> full 48-cycle sweep with correct results.
REQ-037 start held high through the sweep and FIN -> exactly one sweep per IDLE entry; back-to-back sweeps separated by one IDLE cycle; results of each sweep are cleared only on the next accepted start.
